// File: rtl/riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// riscv_fetch_unit
//   Instruction-fetch stage for the pipelined RISC-V core. Issues in-order,
//   word-aligned requests to a latency-tolerant instruction memory. Returned
//   words are buffered in a DEPTH-slot prefetch queue and presented to decode
//   as {pc, instr} under a valid/ready handshake. A redirect from execute
//   flushes the queue and marks every request still in flight as stale.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   imem_req_*        request channel (valid/ready, word-aligned address)
//   imem_resp_*       response channel (in order, never back-pressured)
//   redirect_*        single-cycle taken branch/jump and its target
//   if_*              decode channel: head-of-queue pc/instr, valid/ready
// -----------------------------------------------------------------------------
module riscv_fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);

    localparam int unsigned     CW       = $clog2(DEPTH + 1);
    localparam int unsigned     PW       = $clog2(DEPTH);
    localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_IDX) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1'b1);
        end
        return r;
    endfunction

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
    logic [CW-1:0]   cnt_q,  cnt_d;
    logic [CW-1:0]   out_q,  out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [XLEN-1:0] pc_buf_q    [DEPTH];
    logic [31:0]     instr_buf_q [DEPTH];

    logic            req_fire_s;
    logic            drop_hit_s;
    logic            push_s;
    logic            pop_s;
    logic [CW:0]     occ_s;
    logic [XLEN-1:0] redir_target_s;
    logic            unused_redir_lsb_s;

    // Queued entries plus in-flight requests form the credit pool; a request
    // is only issued while a slot is guaranteed for its response.
    assign occ_s          = {1'b0, cnt_q} + {1'b0, out_q};
    assign redir_target_s = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redir_lsb_s = ^redirect_pc[1:0];

    assign imem_req_valid = !reset && !redirect_valid && (occ_s < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    assign if_valid       = !reset && (cnt_q != {CW{1'b0}});
    assign if_pc          = pc_buf_q[head_q];
    assign if_instr       = instr_buf_q[head_q];

    assign req_fire_s = imem_req_valid && imem_req_ready;
    assign drop_hit_s = imem_resp_valid && (drop_q != {CW{1'b0}});
    assign push_s     = imem_resp_valid && !drop_hit_s && !redirect_valid;
    assign pop_s      = if_valid && if_ready && !redirect_valid;

    // Next-state: redirect overrides request, push and pop in the same cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        drop_d     = drop_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect_valid) begin
            fetch_pc_d = redir_target_s;
            resp_pc_d  = redir_target_s;
            cnt_d      = {CW{1'b0}};
            head_d     = {PW{1'b0}};
            tail_d     = {PW{1'b0}};
            // Everything still outstanding after this cycle's response is stale.
            out_d      = out_q - CW'(imem_resp_valid);
            drop_d     = out_q - CW'(imem_resp_valid);
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            out_d = out_q + CW'(req_fire_s) - CW'(imem_resp_valid);
            if (drop_hit_s) begin
                drop_d = drop_q - CW'(1'b1);
            end else begin
                drop_d = drop_q;
            end
            if (push_s) begin
                resp_pc_d = resp_pc_q + PC_STEP;
                tail_d    = ptr_inc(tail_q);
            end else begin
                resp_pc_d = resp_pc_q;
                tail_d    = tail_q;
            end
            if (pop_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // State and queue storage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            cnt_q      <= {CW{1'b0}};
            out_q      <= {CW{1'b0}};
            drop_q     <= {CW{1'b0}};
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_buf_q[i]    <= {XLEN{1'b0}};
                instr_buf_q[i] <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (push_s) begin
                pc_buf_q[tail_q]    <= resp_pc_q;
                instr_buf_q[tail_q] <= imem_resp_data;
            end else begin
                pc_buf_q[tail_q]    <= pc_buf_q[tail_q];
                instr_buf_q[tail_q] <= instr_buf_q[tail_q];
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch_unit
//   Bench for riscv_fetch_unit (XLEN=64, DEPTH=4, RESET_PC=0). An in-bench
//   instruction memory with per-request latency feeds the DUT. A reference
//   model tags every in-flight request with its address and a stale flag and
//   keeps the decode-visible queue as a plain queue of {pc, instr}; outputs
//   are compared against it every cycle. Directed phases add literal checks.
// -----------------------------------------------------------------------------
module tb_riscv_fetch_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk;
    logic            reset;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;

    riscv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; bit stale; } mreq_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;

    mreq_t       mem_q[$];   // requests in flight, in order
    ent_t        m_q[$];     // entries decode may see
    logic [63:0] m_fetch;    // next address the DUT must request
    logic [63:0] exp_dec;    // golden next-PC of the decode stream
    int          last_due;
    int          cyc;
    int          tests;
    int          fails;
    logic [63:0] req_log[$];
    logic [63:0] dec_log[$];
    logic [31:0] ins_log[$];
    int          dec_cyc[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] ^ 32'h13A5_0000) + a[63:32];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        req_log.delete(); dec_log.delete(); ins_log.delete(); dec_cyc.delete();
    endtask

    // Per-cycle compare against the model, then advance the model.
    task automatic check_cycle(input int lat);
        bit    exp_rv, exp_iv, pop;
        int    due;
        mreq_t r;
        if (reset) begin
            chk("rst_req_valid", imem_req_valid, 64'd0);
            chk("rst_if_valid", if_valid, 64'd0);
            mem_q.delete(); m_q.delete();
            m_fetch = 64'h0; exp_dec = 64'h0; last_due = cyc;
            return;
        end
        exp_rv = !redirect_valid && ((m_q.size() + mem_q.size()) < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, m_fetch);
        exp_iv = (m_q.size() != 0);
        chk("if_valid", if_valid, exp_iv);
        if (exp_iv) begin
            chk("if_pc", if_pc, m_q[0].pc);
            chk("if_instr", if_instr, m_q[0].instr);
        end
        pop = exp_iv && if_ready && !redirect_valid;
        if (pop) begin
            chk("stream_pc", if_pc, exp_dec);
            exp_dec = exp_dec + 64'd4;
            dec_log.push_back(if_pc); ins_log.push_back(if_instr); dec_cyc.push_back(cyc);
            void'(m_q.pop_front());
        end
        if (imem_resp_valid) begin
            r = mem_q.pop_front();
            if (!r.stale && !redirect_valid) m_q.push_back('{pc: r.addr, instr: mem_word(r.addr)});
        end
        if (exp_rv && imem_req_ready) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: m_fetch, due: due, stale: 1'b0});
            req_log.push_back(imem_req_addr);
            m_fetch = m_fetch + 64'd4;
        end
        if (redirect_valid) begin
            m_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            m_fetch = {redirect_pc[63:2], 2'b00};
            exp_dec = {redirect_pc[63:2], 2'b00};
        end
    endtask

    // One clock cycle: drive inputs after the edge, let them settle, compare.
    task automatic step(input bit rst, input bit rv, input logic [63:0] rpc,
                        input bit rdy, input bit qrdy, input int lat);
        @(posedge clk);
        #1;
        reset = rst; redirect_valid = rv; redirect_pc = rpc;
        if_ready = rdy; imem_req_ready = qrdy;
        if (!rst && mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        check_cycle(lat);
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1);
        step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1);
        clear_logs();
    endtask

    initial begin
        int t0, r, n4;
        logic [63:0] tgt;
        tests = 0; fails = 0; cyc = 0; last_due = 0;
        m_fetch = 64'h0; exp_dec = 64'h0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
        if_ready = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

        // T1: 1-cycle memory, decode always ready
        do_reset();
        t0 = cyc;
        repeat (8) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1);
        chk("t1_nreq_ge4", req_log.size() >= 4, 64'd1);
        chk("t1_npop_ge5", dec_log.size() >= 5, 64'd1);
        for (int k = 0; k < 4; k++) if (req_log.size() > k) chk("t1_req_addr", req_log[k], 64'(4 * k));
        for (int k = 0; k < 5; k++) if (dec_log.size() > k) begin
            chk("t1_dec_pc", dec_log[k], 64'(4 * k));
            chk("t1_dec_cycle", 64'(dec_cyc[k]), 64'(t0 + 2 + k));
        end

        // T2: decode stalled fills exactly DEPTH slots, then drains in order
        do_reset();
        repeat (10) step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1);
        chk("t2_nreq", 64'(req_log.size()), 64'd4);
        chk("t2_req_valid_full", imem_req_valid, 64'd0);
        chk("t2_if_valid_held", if_valid, 64'd1);
        chk("t2_if_pc_held", if_pc, 64'h0);
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1);
        chk("t2_ndrain", 64'(dec_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) if (dec_log.size() > k) chk("t2_drain_pc", dec_log[k], 64'(4 * k));

        // T3: 3-cycle memory, redirect with 3 requests in flight
        do_reset();
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 3);
        r = cyc;
        step(1'b0, 1'b1, 64'h100, 1'b1, 1'b1, 3);
        repeat (12) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 3);
        chk("t3_npop_ge2", dec_log.size() >= 2, 64'd1);
        if (dec_log.size() >= 2) begin
            chk("t3_first_pc", dec_log[0], 64'h100);
            chk("t3_first_instr", 64'(ins_log[0]), 64'h13A5_0100);
            chk("t3_first_cycle", 64'(dec_cyc[0]), 64'(r + 5));
            chk("t3_second_pc", dec_log[1], 64'h104);
        end

        // T4: redirect together with a response and a decode pop
        do_reset();
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 2);
        r = cyc;
        step(1'b0, 1'b1, 64'h300, 1'b1, 1'b1, 2);
        chk("t4_resp_in_redirect", imem_resp_valid, 64'd1);
        chk("t4_head_in_redirect", if_valid, 64'd1);
        step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 2);
        chk("t4_empty_after", if_valid, 64'd0);
        repeat (8) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 2);
        chk("t4_npop_ge1", dec_log.size() >= 1, 64'd1);
        if (dec_log.size() >= 1) begin
            chk("t4_first_pc", dec_log[0], 64'h300);
            chk("t4_first_cycle", 64'(dec_cyc[0]), 64'(r + 4));
        end

        // T5: misaligned target, then back-to-back redirects
        do_reset();
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1);
        clear_logs();
        step(1'b0, 1'b1, 64'h203, 1'b1, 1'b1, 1);
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1);
        chk("t5_align_npop", dec_log.size() >= 1, 64'd1);
        if (dec_log.size() >= 1) chk("t5_align_pc", dec_log[0], 64'h200);
        clear_logs();
        step(1'b0, 1'b1, 64'h400, 1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 64'h800, 1'b1, 1'b1, 1);
        repeat (8) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1);
        n4 = 0;
        foreach (req_log[i]) if (req_log[i][63:8] == 56'h4) n4++;
        foreach (dec_log[i]) if (dec_log[i][63:8] == 56'h4) n4++;
        chk("t5_no_0x400_stream", 64'(n4), 64'd0);
        chk("t5_pair_npop", dec_log.size() >= 2, 64'd1);
        if (dec_log.size() >= 2) begin
            chk("t5_pair_pc0", dec_log[0], 64'h800);
            chk("t5_pair_pc1", dec_log[1], 64'h804);
        end

        // T6: random ready, latency, redirects (incl. near address wrap), rare reset
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            tgt = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) tgt = {56'hFF_FFFF_FFFF_FFFF, 8'($urandom())};
            step($urandom_range(0, 999) == 0, $urandom_range(0, 15) == 0, tgt,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(1, 4));
        end
        chk("t6_progress", dec_log.size() > 500, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
